// File: rtl/q_meas_sequencer_if.sv
// rtl/q_meas_sequencer_if.sv - datapath and result-port signals of the measurement sequencer
// master = sequencer side, slave = datapath/consumer side.
interface q_meas_sequencer_if #(
    parameter int BUS_WIDTH = 10
);
    logic                 meas_start;
    logic                 meas_ready;
    logic [BUS_WIDTH-1:0] meas_q;
    logic                 out_valid;
    logic                 out_ack;
    logic [BUS_WIDTH-1:0] out_q;
    logic                 out_err;

    modport master (
        output meas_start, out_valid, out_q, out_err,
        input  meas_ready, meas_q, out_ack
    );

    modport slave (
        input  meas_start, out_valid, out_q, out_err,
        output meas_ready, meas_q, out_ack
    );
endinterface

// File: rtl/q_meas_sequencer.sv
// rtl/q_meas_sequencer.sv - charge-measurement sequencer: settle, acquire, average, watchdog
// Optional Q_SEQ_READY_SYNC_EN adds a 2-flop synchroniser on meas_ready.
module q_meas_sequencer #(
    parameter int BUS_WIDTH     = 10,
    parameter int N_AVG_LOG2    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               cont,
    output logic               busy,
    q_meas_sequencer_if.master bus
);
    localparam int ACC_W = BUS_WIDTH + N_AVG_LOG2;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [N_AVG_LOG2:0] CNT_FULL = (N_AVG_LOG2 + 1)'(1) << N_AVG_LOG2;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, OUTPUT} state_t;

    state_t                   state;
    logic [ACC_W-1:0]         acc;
    logic [N_AVG_LOG2:0]      cnt;
    logic [TIMEOUT_WIDTH-1:0] wdog;
    logic [SET_W-1:0]         settle;
    logic                     ready_r;
    logic                     ready_prev;
    logic                     meas_start_r;
    logic                     out_valid_r;
    logic [BUS_WIDTH-1:0]     out_q_r;
    logic                     out_err_r;

    logic                     ready_edge;
    logic [ACC_W-1:0]         acc_sum;
    logic [N_AVG_LOG2:0]      cnt_inc;
    logic [TIMEOUT_WIDTH-1:0] wdog_inc;
    logic                     timeout;

    assign ready_edge = ready_r & ~ready_prev;
    assign acc_sum    = acc + ACC_W'(bus.meas_q);
    assign cnt_inc    = cnt + 1'b1;
    assign wdog_inc   = wdog + 1'b1;
    assign timeout    = &wdog_inc;

    assign bus.meas_start = meas_start_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_q      = out_q_r;
    assign bus.out_err    = out_err_r;

`ifdef Q_SEQ_READY_SYNC_EN
    logic ready_s1;
    logic ready_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_s1 <= 1'b0;
            ready_s2 <= 1'b0;
        end else begin
            ready_s1 <= bus.meas_ready;
            ready_s2 <= ready_s1;
        end
    end
`else
    logic ready_s2;
    assign ready_s2 = bus.meas_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            wdog         <= '0;
            settle       <= '0;
            ready_r      <= 1'b0;
            ready_prev   <= 1'b0;
            meas_start_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_q_r      <= '0;
            out_err_r    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ready_r    <= ready_s2;
            ready_prev <= ready_r;
            case (state)
                IDLE: begin
                    acc          <= '0;
                    cnt          <= '0;
                    meas_start_r <= 1'b0;
                    if (trigger) begin
                        state  <= ARM;
                        busy   <= 1'b1;
                        settle <= '0;
                    end
                end
                ARM: begin
                    wdog <= '0;
                    if (settle == SET_W'(SETTLE_CYCLES - 1)) begin
                        state        <= MEASURE;
                        meas_start_r <= 1'b1;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                MEASURE: begin
                    wdog <= wdog_inc;
                    // A ready edge takes priority over a simultaneous watchdog expiry.
                    if (ready_edge) begin
                        acc          <= acc_sum;
                        cnt          <= cnt_inc;
                        meas_start_r <= 1'b0;
                        if (cnt_inc == CNT_FULL) begin
                            state       <= OUTPUT;
                            out_valid_r <= 1'b1;
                            out_q_r     <= acc_sum[ACC_W-1:N_AVG_LOG2];
                            out_err_r   <= 1'b0;
                        end else begin
                            state  <= ARM;
                            settle <= '0;
                        end
                    end else if (timeout) begin
                        acc          <= '0;
                        meas_start_r <= 1'b0;
                        state        <= OUTPUT;
                        out_valid_r  <= 1'b1;
                        out_q_r      <= '0;
                        out_err_r    <= 1'b1;
                    end
                end
                OUTPUT: begin
                    meas_start_r <= 1'b0;
                    if (bus.out_ack) begin
                        out_valid_r <= 1'b0;
                        out_q_r     <= '0;
                        out_err_r   <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
                        if (cont) begin
                            state  <= ARM;
                            settle <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_q_meas_sequencer.sv
// tb/tb_q_meas_sequencer.sv - scoreboard bench for q_meas_sequencer
module tb_q_meas_sequencer;
    localparam int BW = 10;
    localparam int NL = 2;
    localparam int SC = 4;
    localparam int TW = 4;
    localparam int NR = 1 << NL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trigger = 1'b0;
    logic cont = 1'b0;
    logic busy;

    q_meas_sequencer_if #(.BUS_WIDTH(BW)) bus ();

    q_meas_sequencer #(
        .BUS_WIDTH(BW), .N_AVG_LOG2(NL), .SETTLE_CYCLES(SC), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .cont(cont), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit err;
    } res_t;

    res_t exp_q[$];
    int   rd_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   dead = 0;
    bit   have_cur = 0;
    int   consumed = 0;
    int   bp_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath model: answers each meas_start high period with one ready pulse after a random latency.
    int dp_cnt = 0;
    int dp_lat = 1;
    bit dp_done = 0;
    initial begin
        bus.meas_ready = 1'b0;
        bus.meas_q = '0;
        forever begin
            @(negedge clk);
            bus.meas_ready = 1'b0;
            if (bus.meas_start !== 1'b1) begin
                dp_cnt = 0;
                dp_done = 0;
                dp_lat = $urandom_range(1, 5);
            end else if (!dp_done && !dead && rd_q.size() > 0) begin
                dp_cnt++;
                if (dp_cnt >= dp_lat) begin
                    bus.meas_q = BW'(rd_q.pop_front());
                    bus.meas_ready = 1'b1;
                    dp_done = 1;
                end
            end
        end
    end

    // Monitor/consumer: pops the expected result when out_valid appears and holds it until acked.
    res_t cur;
    int   hold = 0;
    bit   acked = 0;
    bit   cont_at_ack = 0;
    bit   watch = 0;
    int   zc = 0;
    initial begin
        bus.out_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_cur = 0;
                acked = 0;
                watch = 0;
                bus.out_ack = 1'b0;
            end else begin
                if (acked) begin
                    acked = 0;
                    bus.out_ack = 1'b0;
                    have_cur = 0;
                    consumed++;
                    check("valid_drop_after_ack", bus.out_valid, 0);
                    check("busy_after_ack", busy, cont_at_ack);
                    if (cont_at_ack) begin
                        watch = 1;
                        zc = 0;
                    end
                end else if (bus.out_valid === 1'b1) begin
                    if (!have_cur) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: got q=%0d err=%0d expected no result", bus.out_q, bus.out_err);
                            cur = '{q: -1, err: 1'b1};
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        have_cur = 1;
                        hold = (bp_hold > 0) ? bp_hold : $urandom_range(0, 3);
                        bp_hold = 0;
                    end
                    check("out_q", bus.out_q, cur.q);
                    check("out_err", bus.out_err, cur.err);
                    if (hold == 0) begin
                        bus.out_ack = 1'b1;
                        acked = 1;
                        cont_at_ack = cont;
                    end else begin
                        hold--;
                    end
                end
                if (watch) begin
                    if (bus.meas_start === 1'b1) begin
                        check("cont_settle_cycles", zc, SC);
                        watch = 0;
                    end else begin
                        zc++;
                        if (zc > 200) begin
                            check("cont_restart", zc, SC);
                            watch = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic queue_burst(input int r0, input int r1, input int r2, input int r3);
        int s;
        s = r0 + r1 + r2 + r3;
        rd_q.push_back(r0);
        rd_q.push_back(r1);
        rd_q.push_back(r2);
        rd_q.push_back(r3);
        exp_q.push_back('{q: s / NR, err: 1'b0});
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_start(input logic val, input string name);
        int n;
        n = 0;
        while (bus.meas_start !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(name, bus.meas_start, val);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || have_cur || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    int cnt_hi;
    int c0;
    int n;
    int rises;
    logic prev_start;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_meas_start", bus.meas_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_q", bus.out_q, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic average with trigger-to-start timing and re-arm settle length
        queue_burst(30, 60, 90, 120);
        pulse_trigger();
        check("busy_t1", busy, 1);
        check("start_low_t1", bus.meas_start, 0);
        repeat (SC - 1) @(negedge clk);
        check("start_low_settle", bus.meas_start, 0);
        @(negedge clk);
        check("start_rise", bus.meas_start, 1);
        wait_start(1'b0, "first_reading");
        cnt_hi = 0;
        while (bus.meas_start === 1'b0 && cnt_hi < 100) begin
            @(negedge clk);
            cnt_hi++;
        end
        check("rearm_low_cycles", cnt_hi, SC);
        drain("drain_basic");

        // Truncation
        queue_burst(1, 1, 1, 2);
        pulse_trigger();
        drain("drain_trunc");

        // Random bursts
        for (int b = 0; b < 6; b++) begin
            queue_burst($urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1023), $urandom_range(0, 1023));
            pulse_trigger();
            drain("drain_random");
        end
        queue_burst(1023, 1023, 1023, 1023);
        pulse_trigger();
        drain("drain_max");

        // Watchdog timeout with a dead datapath
        dead = 1;
        exp_q.push_back('{q: 0, err: 1'b1});
        pulse_trigger();
        wait_start(1'b1, "timeout_start");
        cnt_hi = 0;
        while (bus.meas_start === 1'b1 && cnt_hi < 100) begin
            @(negedge clk);
            cnt_hi++;
        end
        check("timeout_cycles", cnt_hi, (1 << TW) - 1);
        drain("drain_timeout");
        dead = 0;

        // Backpressure: ack withheld 10 cycles, triggers in the window must be dropped
        bp_hold = 10;
        queue_burst($urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
        pulse_trigger();
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("bp_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse_trigger();
        end
        drain("drain_bp");
        repeat (20) @(negedge clk);
        check("bp_trigger_ignored_busy", busy, 0);
        check("bp_trigger_ignored_valid", bus.out_valid, 0);

        // Continuous mode: three results from one trigger
        cont = 1'b1;
        c0 = consumed;
        for (int b = 0; b < 3; b++)
            queue_burst($urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1023), $urandom_range(0, 1023));
        pulse_trigger();
        n = 0;
        while (consumed < c0 + 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("cont_progress", consumed, c0 + 2);
        cont = 1'b0;
        drain("drain_cont");

        // Reset during the second reading, then a clean burst
        for (int i = 0; i < NR; i++) rd_q.push_back(500);
        pulse_trigger();
        rises = 0;
        prev_start = 1'b0;
        n = 0;
        while (rises < 2 && n < 500) begin
            if (bus.meas_start === 1'b1 && prev_start === 1'b0) rises++;
            prev_start = bus.meas_start;
            if (rises < 2) @(negedge clk);
            n++;
        end
        if (n >= 500) check("reset_wait_second", rises, 2);
        check("pre_reset_start", bus.meas_start, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_meas_start", bus.meas_start, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_q", bus.out_q, 0);
        check("mid_rst_out_err", bus.out_err, 0);
        check("mid_rst_busy", busy, 0);
        rd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        queue_burst(40, 40, 40, 40);
        pulse_trigger();
        drain("drain_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
